// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM states and read FIFO sizing.
package sram_burst_ctrl_pkg;

    localparam int unsigned RD_FIFO_DEPTH = 4;
    localparam int unsigned RD_CNT_WIDTH  = $clog2(RD_FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WFIN,
        RD,
        DRAIN
    } state_t;

endpackage

// File: rtl/sram_burst_ctrl_rd_fifo.sv
// Synchronous read-data FIFO with occupancy count; push and pop in one cycle keep the count unchanged.
module sram_rd_fifo
    import sram_burst_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = RD_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a synchronous single-port SRAM: write bursts stream one beat per cycle,
// read bursts are credit-limited into a small output FIFO so backpressure never drops data.
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_done
);

    localparam logic [RD_CNT_WIDTH:0] CREDIT_MAX = (RD_CNT_WIDTH + 1)'(RD_FIFO_DEPTH);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [LEN_WIDTH-1:0]    beat_cnt;
    logic [1:0]              rd_pipe;
    logic [RD_CNT_WIDTH-1:0] fifo_count;
    logic [RD_CNT_WIDTH:0]   credit_used;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    cmd_fire;
    logic                    wr_fire;
    logic                    rd_issue;
    logic                    last_beat;
    logic                    drain_done;

    assign o_rdata_valid = !fifo_empty;
    assign fifo_pop      = o_rdata_valid && i_rdata_ready;
    assign last_beat     = (beat_cnt == '0);
    assign credit_used   = {1'b0, fifo_count}
                         + {{RD_CNT_WIDTH{1'b0}}, rd_pipe[0]}
                         + {{RD_CNT_WIDTH{1'b0}}, rd_pipe[1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The first read beat is issued on the accept edge itself so data lands in the FIFO two edges later.
    always_comb begin
        next_state    = state;
        cmd_fire      = 1'b0;
        wr_fire       = 1'b0;
        rd_issue      = 1'b0;
        drain_done    = 1'b0;
        o_cmd_ready   = (state == IDLE);
        o_wdata_ready = (state == WR);
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_fire = 1'b1;
                    if (i_cmd_write) begin
                        next_state = WR;
                    end else begin
                        rd_issue   = 1'b1;
                        next_state = (i_cmd_len == '0) ? DRAIN : RD;
                    end
                end
            end
            WR: begin
                if (i_wdata_valid) begin
                    wr_fire = 1'b1;
                    if (last_beat) begin
                        next_state = WFIN;
                    end
                end
            end
            WFIN: next_state = IDLE;
            RD: begin
                if (credit_used < CREDIT_MAX) begin
                    rd_issue = 1'b1;
                    if (last_beat) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_pipe == '0 &&
                    (fifo_empty || (fifo_count == RD_CNT_WIDTH'(1) && fifo_pop))) begin
                    drain_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_cnt    <= '0;
            beat_cnt    <= '0;
            rd_pipe     <= '0;
            o_mem_addr  <= '0;
            o_mem_write <= 1'b0;
            o_mem_wdata <= '0;
            o_done      <= 1'b0;
        end else begin
            o_done      <= (state == WFIN) || drain_done;
            o_mem_write <= wr_fire;
            rd_pipe     <= {rd_pipe[0], rd_issue};
            if (cmd_fire && i_cmd_write) begin
                addr_cnt <= i_cmd_addr;
                beat_cnt <= i_cmd_len;
            end else if (cmd_fire) begin
                addr_cnt <= i_cmd_addr + ADDR_WIDTH'(1);
                beat_cnt <= i_cmd_len - LEN_WIDTH'(1);
            end else if (wr_fire || rd_issue) begin
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            end
            if (wr_fire) begin
                o_mem_addr  <= addr_cnt;
                o_mem_wdata <= i_wdata;
            end else if (rd_issue) begin
                o_mem_addr <= cmd_fire ? i_cmd_addr : addr_cnt;
            end
        end
    end

    sram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (rd_pipe[1]),
        .wdata (i_mem_rdata),
        .pop   (fifo_pop),
        .rdata (o_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl with a behavioural synchronous SRAM attached.
module tb_sram_burst_ctrl;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [4:0]  i_cmd_addr;
    logic [3:0]  i_cmd_len;
    logic        i_wdata_valid;
    logic        o_wdata_ready;
    logic [31:0] i_wdata;
    logic        o_rdata_valid;
    logic        i_rdata_ready;
    logic [31:0] o_rdata;
    logic [4:0]  o_mem_addr;
    logic        o_mem_write;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram   [32];
    logic [31:0] golden [32];
    logic [36:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    always #5 clk = ~clk;

    sram_burst_ctrl #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_len     (i_cmd_len),
        .i_wdata_valid (i_wdata_valid),
        .o_wdata_ready (o_wdata_ready),
        .i_wdata       (i_wdata),
        .o_rdata_valid (o_rdata_valid),
        .i_rdata_ready (i_rdata_ready),
        .o_rdata       (o_rdata),
        .o_mem_addr    (o_mem_addr),
        .o_mem_write   (o_mem_write),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .o_done        (o_done)
    );

    always @(posedge clk) begin
        if (o_mem_write) sram[o_mem_addr] <= o_mem_wdata;
        i_mem_rdata <= sram[o_mem_addr];
    end

    task automatic test_reset();
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
        i_wdata_valid = 1'b0; i_wdata = '0; i_rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", o_cmd_ready); end
        checks++; if (o_wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready: got %b expected 0", o_wdata_ready); end
        checks++; if (o_rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b expected 0", o_rdata_valid); end
        checks++; if (o_mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", o_mem_write); end
        checks++; if (o_mem_addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", o_mem_addr); end
        checks++; if (o_mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", o_mem_wdata); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
        i_rst = 1'b0;
    endtask

    task automatic run_write(input string name, input logic [4:0] addr, input logic [3:0] len,
                             input logic [31:0] base, input bit toggle);
        int beats = int'(len) + 1;
        int sent = 0, strobes = 0, first_s = -1, last_s = -1, cyc = 0;
        bit done_seen = 1'b0, tog = 1'b0;
        logic [36:0] exp;
        for (int i = 0; i < beats; i++) begin
            logic [4:0] a = addr + 5'(i);
            exp_wr_q.push_back({a, base + 32'(i)});
            golden[a] = base + 32'(i);
        end
        @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_cmd_ready: got %b expected 1", name, o_cmd_ready); end
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = addr; i_cmd_len = len;
        i_wdata_valid = 1'b1; i_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        while (!done_seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_cmd_valid = 1'b0;
            if (o_mem_write) begin
                strobes++;
                if (first_s < 0) first_s = cyc;
                last_s = cyc;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++; $display("FAIL %s_extra_strobe: got addr %h data %h expected none", name, o_mem_addr, o_mem_wdata);
                end else begin
                    exp = exp_wr_q.pop_front();
                    if ({o_mem_addr, o_mem_wdata} !== exp) begin
                        errors++; $display("FAIL %s_strobe: got %h/%h expected %h/%h", name, o_mem_addr, o_mem_wdata, exp[36:32], exp[31:0]);
                    end
                end
            end
            if (o_done) begin
                done_seen = 1'b1;
                checks++; if (cyc != last_s + 1) begin errors++; $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, cyc, last_s + 1); end
                checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_with_done: got %b expected 1", name, o_cmd_ready); end
            end
            if (o_wdata_ready) begin
                i_wdata_valid = 1'b0;
                if (sent < beats && (!toggle || tog)) begin
                    i_wdata_valid = 1'b1; i_wdata = base + 32'(sent); sent++;
                end
                tog = !tog;
            end else begin
                i_wdata_valid = 1'b1; i_wdata = 32'hBAD0_0000 + 32'(cyc);
            end
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL %s_done_timeout: got no done expected done", name); end
        checks++; if (strobes != beats) begin errors++; $display("FAIL %s_strobe_count: got %0d expected %0d", name, strobes, beats); end
        checks++;
        if (last_s - first_s != (toggle ? 2 * (beats - 1) : beats - 1)) begin
            errors++; $display("FAIL %s_strobe_span: got %0d expected %0d", name, last_s - first_s, toggle ? 2 * (beats - 1) : beats - 1);
        end
    endtask

    task automatic run_read(input string name, input logic [4:0] addr, input logic [3:0] len, input int stall);
        int beats = int'(len) + 1;
        int pops = 0, first_v = -1, last_p = -1, cyc = 0;
        bit done_seen = 1'b0, wr_seen = 1'b0;
        logic [31:0] exp;
        for (int i = 0; i < beats; i++) exp_rd_q.push_back(golden[addr + 5'(i)]);
        @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_cmd_ready: got %b expected 1", name, o_cmd_ready); end
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = addr; i_cmd_len = len;
        i_rdata_ready = (stall == 0);
        @(posedge clk);
        while (!done_seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            i_cmd_valid = 1'b0;
            if (o_mem_write) wr_seen = 1'b1;
            if (stall > 0 && cyc == stall) begin
                checks++;
                if (o_mem_addr !== addr + 5'd3) begin
                    errors++; $display("FAIL %s_credit_limit: got addr %h expected %h", name, o_mem_addr, addr + 5'd3);
                end
            end
            i_rdata_ready = (cyc >= stall);
            if (o_rdata_valid && first_v < 0) first_v = cyc;
            if (o_rdata_valid && i_rdata_ready) begin
                pops++; last_p = cyc;
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++; $display("FAIL %s_extra_beat: got %h expected none", name, o_rdata);
                end else begin
                    exp = exp_rd_q.pop_front();
                    if (o_rdata !== exp) begin errors++; $display("FAIL %s_rdata: got %h expected %h", name, o_rdata, exp); end
                end
            end
            if (o_done) begin
                done_seen = 1'b1;
                checks++; if (cyc != last_p + 1) begin errors++; $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, cyc, last_p + 1); end
            end
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL %s_done_timeout: got no done expected done", name); end
        checks++; if (pops != beats) begin errors++; $display("FAIL %s_beat_count: got %0d expected %0d", name, pops, beats); end
        checks++; if (wr_seen) begin errors++; $display("FAIL %s_write_during_read: got 1 expected 0", name); end
        if (stall == 0) begin
            checks++; if (first_v != 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", name, first_v); end
            checks++; if (last_p - first_v != beats - 1) begin errors++; $display("FAIL %s_throughput: got %0d expected %0d", name, last_p - first_v, beats - 1); end
        end
        exp_rd_q.delete();
    endtask

    task automatic test_write_burst();
        run_write("wr_a", 5'd3, 4'd3, 32'hA0, 1'b0);
    endtask

    task automatic test_read_burst();
        run_read("rd_a", 5'd3, 4'd3, 0);
    endtask

    task automatic test_wrap();
        run_write("wr_wrap", 5'd30, 4'd3, 32'hB0, 1'b0);
        run_read("rd_wrap", 5'd30, 4'd3, 0);
    endtask

    task automatic test_write_gaps();
        run_write("wr_gap", 5'd8, 4'd3, 32'hC0, 1'b1);
        run_read("rd_gap", 5'd8, 4'd3, 0);
    endtask

    task automatic test_backpressure();
        run_write("wr_long", 5'd0, 4'd15, 32'hD00, 1'b0);
        run_read("rd_stall", 5'd0, 4'd15, 10);
    endtask

    task automatic test_reset_mid_write();
        int sent = 0, cyc = 0;
        bit bad_write = 1'b0, bad_done = 1'b0;
        logic [36:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp_wr_q.push_back({5'd16 + 5'(i), 32'hE0 + 32'(i)});
            golden[5'd16 + 5'(i)] = 32'hE0 + 32'(i);
        end
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 5'd16; i_cmd_len = 4'd7; i_wdata_valid = 1'b0;
        @(posedge clk);
        while (!i_rst && cyc < 30) begin
            @(negedge clk);
            cyc++;
            i_cmd_valid = 1'b0;
            if (o_mem_write) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++; $display("FAIL rst_mid_extra_strobe: got addr %h expected none", o_mem_addr);
                end else begin
                    exp = exp_wr_q.pop_front();
                    if ({o_mem_addr, o_mem_wdata} !== exp) begin
                        errors++; $display("FAIL rst_mid_strobe: got %h/%h expected %h/%h", o_mem_addr, o_mem_wdata, exp[36:32], exp[31:0]);
                    end
                end
            end
            if (sent == 4) begin
                i_rst = 1'b1; i_wdata_valid = 1'b1; i_wdata = 32'hE4;
            end else if (o_wdata_ready) begin
                i_wdata_valid = 1'b1; i_wdata = 32'hE0 + 32'(sent); sent++;
            end
        end
        checks++; if (!i_rst) begin errors++; $display("FAIL rst_mid_reach_beat: got %0d beats expected 4", sent); end
        @(negedge clk);
        i_rst = 1'b0;
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", o_cmd_ready); end
        checks++; if (o_wdata_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_wdata_ready: got %b expected 0", o_wdata_ready); end
        for (int i = 0; i < 8; i++) begin
            if (o_mem_write) bad_write = 1'b1;
            if (o_done) bad_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad_write) begin errors++; $display("FAIL rst_mid_no_write: got 1 expected 0"); end
        checks++; if (bad_done) begin errors++; $display("FAIL rst_mid_no_done: got 1 expected 0"); end
        checks++; if (exp_wr_q.size() != 0) begin errors++; $display("FAIL rst_mid_pending: got %0d expected 0", exp_wr_q.size()); end
        exp_wr_q.delete();
    endtask

    task automatic test_back_to_back();
        run_read("rd_after_rst", 5'd16, 4'd3, 0);
        run_write("wr_b2b", 5'd20, 4'd0, 32'hF0, 1'b0);
        run_read("rd_b2b", 5'd20, 4'd0, 0);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_write_gaps();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst length field width; beats = i_cmd_len+1.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_cmd_valid / o_cmd_ready  in/out  1  command handshake; transfer on edge with both high.
REQ-008 i_cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-009 i_cmd_addr  in  ADDR_WIDTH  burst start word address.
REQ-010 i_cmd_len  in  LEN_WIDTH  beats minus one.
REQ-011 i_wdata_valid / o_wdata_ready  in/out  1  write-data handshake.
REQ-012 i_wdata  in  DATA_WIDTH  write beat.
REQ-013 o_rdata_valid / i_rdata_ready  out/in  1  read-data handshake.
REQ-014 o_rdata  out  DATA_WIDTH  read beat.
REQ-015 o_mem_addr  out  ADDR_WIDTH  SRAM address, registered.
REQ-016 o_mem_write  out  1  SRAM write strobe, registered; SRAM reads whenever low.
REQ-017 o_mem_wdata  out  DATA_WIDTH  SRAM write data, registered.
REQ-018 i_mem_rdata  in  DATA_WIDTH  SRAM read data; valid one cycle after address presented with o_mem_write=0.
REQ-019 o_done  out  1  one-cycle pulse at burst completion.

Function
REQ-020 FSM states SHALL be IDLE, WR, WFIN, RD, DRAIN.
REQ-021 o_cmd_ready SHALL be high only in IDLE (including the cycle o_done is high).
REQ-022 On command accept: burst address counter <= i_cmd_addr, beat counter <= i_cmd_len; next state WR if i_cmd_write else RD.
REQ-023 WR: o_wdata_ready high; each accepted beat registers o_mem_addr=counter, o_mem_wdata=i_wdata, o_mem_write=1 for the following cycle only; counter increments.
REQ-024 Last write beat accepted -> WFIN (strobe cycle of last beat); next edge -> IDLE with o_done=1 for one cycle.
REQ-025 Write throughput SHALL be one beat per cycle while i_wdata_valid stays high; gaps in i_wdata_valid insert idle cycles with o_mem_write=0.
REQ-026 Read path SHALL contain a 4-entry output FIFO; a read is issued (o_mem_addr<=counter, o_mem_write<=0) when registered occupancy + outstanding reads < 4.
REQ-027 Outstanding reads SHALL be tracked by a 2-stage valid pipeline; i_mem_rdata pushed into FIFO on the edge two edges after issue.
REQ-028 Read latency: command accepted at edge E0 with empty FIFO -> o_rdata_valid high after edge E0+2.
REQ-029 Sustained read throughput SHALL be one beat per cycle when i_rdata_ready held high.
REQ-030 Last read issued -> DRAIN; DRAIN -> IDLE on edge where FIFO becomes empty with no outstanding reads, o_done=1 next cycle.
REQ-031 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-032 Address counter SHALL wrap modulo 2^ADDR_WIDTH (31 -> 0 at default).
REQ-033 o_mem_write SHALL never be high outside a write beat cycle; write data offered outside WR SHALL be ignored (o_wdata_ready low).
REQ-034 Beat order on o_rdata SHALL equal address order.

Reset
REQ-035 i_rst high at an edge: state IDLE, counters 0, FIFO flushed, pipeline valids 0.
REQ-036 Reset values: o_cmd_ready=1 after reset, o_wdata_ready=0, o_rdata_valid=0, o_mem_write=0, o_mem_addr=0, o_mem_wdata=0, o_done=0.
REQ-037 Reset mid-burst SHALL abandon the burst with no further SRAM writes and no o_done.

Structure
REQ-038 Shared package SHALL hold the FSM state enum and RD_FIFO_DEPTH=4.
REQ-039 Output FIFO SHALL be sub-module sram_rd_fifo (synchronous, count output).

Verification
REQ-040 Write addr=3 len=3 data A0..A3 continuous -> o_mem_write 4 consecutive cycles, addrs 3,4,5,6, o_done one cycle after last strobe.
REQ-041 Read addr=3 len=3 after REQ-040, i_rdata_ready=1 -> o_rdata A0..A3 on 4 consecutive cycles, first after edge E0+2, then o_done.
REQ-042 Read addr=30 len=3 -> SRAM addrs 30,31,0,1 in order.
REQ-043 Read len=15 with i_rdata_ready low for 10 cycles -> occupancy+outstanding never exceeds 4, no beat lost or duplicated, all 16 returned in order.
REQ-044 Write len=7, i_rst asserted after beat 3 -> no o_mem_write after reset, o_done stays 0, new command accepted next cycle.
REQ-045 i_wdata_valid toggled every other cycle during write len=3 -> exactly 4 strobes, idle cycles have o_mem_write=0.
